display_buf_streamer: RTL and testbench

Downstream stage of the display buffer updater. On `start` it scans the 160x80 frame region (addresses 0..X_MAX*Y_MAX-1) of the shared display RAM in raster order. Each 8-bit RGB332 pixel is expanded to RGB565 and presented on a valid/ready stream to the LCD SPI driver. A `hold` input lets the updater own the shared RAM port between reads.

---
 rtl/display_buf_streamer.sv | 171 +++++++++++++++++
 tb/tb_display_buf_streamer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_buf_streamer.sv
// display_buf_streamer
// Scans the frame region of the shared display RAM in raster order, expands
// each RGB332 word to RGB565 and streams it to the LCD SPI driver over a
// valid/ready handshake. The updater may hold the RAM port between reads.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no frame in progress; waiting for start
// S_ISSUE   | read for pixel n pending, blocked by hold
// S_WAIT    | read issued; counting RD_LAT edges until dout is valid
// S_PRESENT | pixel n on pix_data with pix_valid high, awaiting pix_ready

module display_buf_streamer #(
   parameter int LEN    = 12800,
   parameter int WIDTH  = 8,
   parameter int X_MAX  = 160,
   parameter int Y_MAX  = 80,
   parameter int RD_LAT = 2,
   parameter int ADDR_W = $clog2(LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   input  logic              hold,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_en,
   input  logic [WIDTH-1:0]  dout,
   output logic [15:0]       pix_data,
   output logic              pix_valid,
   input  logic              pix_ready
);

   localparam int NPIX  = X_MAX * Y_MAX;
   localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
   // Latency down-counter load: terminal count 0 is the dout capture edge.
   localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_PRESENT = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    n_inc;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rd_en_q, rd_en_d;
   logic [15:0]         pix_data_q, pix_data_d;
   logic                pix_valid_q, pix_valid_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic [2:0]          lat_q, lat_d;

   // Bit replication keeps full-scale white at full scale after widening.
   function automatic logic [15:0] rgb332_to_565(input logic [7:0] p);
      return {p[7:5], p[7:6], p[4:2], p[4:2], p[1:0], p[1:0], p[1]};
   endfunction

   assign n_inc = n_q + CNT_W'(1);

   // Next-state and output decode for the scan FSM.
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      addr_d       = addr_q;
      rd_en_d      = 1'b0;
      pix_data_d   = pix_data_q;
      pix_valid_d  = pix_valid_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      lat_d        = lat_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               n_d    = '0;
               if (!hold) begin
                  addr_d  = '0;
                  rd_en_d = 1'b1;
                  lat_d   = LAT_LOAD;
                  state_d = S_WAIT;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            if (!hold) begin
               addr_d  = ADDR_W'(n_q);
               rd_en_d = 1'b1;
               lat_d   = LAT_LOAD;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            // hold is deliberately ignored here: the read is already in flight.
            if (lat_q == 3'd0) begin
               pix_data_d  = rgb332_to_565(dout[7:0]);
               pix_valid_d = 1'b1;
               state_d     = S_PRESENT;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end

         S_PRESENT: begin
            if (pix_ready) begin
               pix_valid_d = 1'b0;
               if (n_q == LAST_PIX) begin
                  busy_d       = 1'b0;
                  frame_done_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  n_d = n_inc;
                  if (!hold) begin
                     addr_d  = ADDR_W'(n_inc);
                     rd_en_d = 1'b1;
                     lat_d   = LAT_LOAD;
                     state_d = S_WAIT;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         addr_q       <= '0;
         rd_en_q      <= 1'b0;
         pix_data_q   <= '0;
         pix_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         lat_q        <= '0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         addr_q       <= addr_d;
         rd_en_q      <= rd_en_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         lat_q        <= lat_d;
      end
   end

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign addr       = addr_q;
   assign rd_en      = rd_en_q;
   assign pix_data   = pix_data_q;
   assign pix_valid  = pix_valid_q;

endmodule

// File: tb/tb_display_buf_streamer.sv
// Bench for display_buf_streamer: behavioural RAM with two-edge read latency,
// scoreboard queue of expected pixels filled at each start, and a negedge
// monitor that checks read addresses, pixel data and pixel timing.

module tb_display_buf_streamer;

   localparam int NPIX = 12800;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic        hold;
   logic [13:0] addr;
   logic        rd_en;
   logic [7:0]  dout;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   logic [7:0]  mem [NPIX];
   logic [15:0] hand [6];
   logic [15:0] exp_q [$];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int s_edge = 0;
   int hs_cnt = 0;
   int rd_exp = 0;
   int fd_cnt = 0;
   bit timing_on = 1'b0;

   display_buf_streamer dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .frame_done(frame_done), .hold(hold), .addr(addr), .rd_en(rd_en),
      .dout(dout), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM read: addr registered at edge E0, data seen by the DUT at E0+2.
   always @(posedge clk) dout <= mem[addr];

   function automatic logic [15:0] conv(input logic [7:0] p);
      int r, g, b, v;
      r = int'(p[7:5]);
      g = int'(p[4:2]);
      b = int'(p[1:0]);
      v = ((r * 4 + r / 2) << 11) | ((g * 9) << 5) | (b * 10 + b / 2);
      return 16'(v);
   endfunction

   function automatic logic [15:0] exp_pix(input int i);
      if (i < 6) return hand[i];
      return conv(mem[i]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic start_frame();
      for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_pix(i));
      rd_exp = 0;
      hs_cnt = 0;
      start  = 1'b1;
      @(posedge clk); #1;
      s_edge = cyc;
      start  = 1'b0;
   endtask

   task automatic wait_pix(input int a, input int lim, input string nm);
      int i;
      i = 0;
      while (!(pix_valid === 1'b1 && addr == 14'(a)) && i < lim) begin
         @(posedge clk); #1;
         i++;
      end
      chk(nm, {31'd0, (pix_valid === 1'b1 && addr == 14'(a))}, 32'd1);
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   initial begin
      logic rd_prev, pv_prev;
      logic [15:0] e;
      rd_prev = 1'b0;
      pv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            rd_prev = 1'b0;
            pv_prev = 1'b0;
         end else begin
            if (rd_en === 1'b1) begin
               chk("rd_addr", {18'd0, addr}, 32'(rd_exp));
               if (rd_prev) chk("rd_en_one_cycle", 32'd1, 32'd0);
               rd_exp++;
            end
            if (pix_valid === 1'b1 && !pv_prev && timing_on)
               chk("pix_timing", 32'(cyc), 32'(s_edge + 3 * hs_cnt + 2));
            if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_pixel", {16'd0, pix_data}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("pix_data", {16'd0, pix_data}, {16'd0, e});
               end
               hs_cnt++;
            end
            if (frame_done === 1'b1) fd_cnt++;
            rd_prev = (rd_en === 1'b1);
            pv_prev = (pix_valid === 1'b1);
         end
      end
   end

   initial begin
      for (int i = 0; i < NPIX; i++) mem[i] = i[7:0];
      mem[0] = 8'hFF; mem[1] = 8'hE0; mem[2] = 8'h1C;
      mem[3] = 8'h03; mem[4] = 8'h00; mem[5] = 8'h92;
      hand[0] = 16'hFFFF; hand[1] = 16'hF800; hand[2] = 16'h07E0;
      hand[3] = 16'h001F; hand[4] = 16'h0000; hand[5] = 16'h9495;

      rst = 1'b1; start = 1'b0; hold = 1'b0; pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {2'd0, busy, frame_done, rd_en, pix_valid, addr, pix_data}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle_outputs", {2'd0, busy, frame_done, rd_en, pix_valid, addr, pix_data}, 32'd0);
      end

      // Frame A: hold, backpressure, ignored start, then reset abort.
      start_frame();
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_read", {17'd0, rd_en, addr}, {17'd0, 1'b1, 14'd0});

      wait_pix(3, 100, "reach_pix3");
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("hold_no_read", {31'd0, rd_en}, 32'd0);
      end
      hold = 1'b0;
      @(posedge clk); #1;
      chk("hold_release_read", {17'd0, rd_en, addr}, {17'd0, 1'b1, 14'd4});
      hold = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("hold_in_wait_valid", {31'd0, pix_valid}, 32'd1);
      chk("hold_in_wait_data", {16'd0, pix_data}, 32'h0000);
      hold = 1'b0;

      wait_pix(7, 100, "reach_pix7");
      pix_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_stable", {14'd0, pix_valid, rd_en, pix_data}, {14'd0, 1'b1, 1'b0, 16'h013F});
         chk("bp_addr", {18'd0, addr}, 32'd7);
      end
      pix_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_next_read", {17'd0, rd_en, addr}, {17'd0, 1'b1, 14'd8});

      wait_pix(100, 500, "reach_pix100");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_while_busy", {17'd0, rd_en, addr}, {17'd0, 1'b1, 14'd101});

      wait_pix(500, 2000, "reach_pix500");
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy_valid", {30'd0, busy, pix_valid}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      chk("abort_no_frame_done", 32'(fd_cnt), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // Frame B: full frame at full throughput with timing checks.
      timing_on = 1'b1;
      start_frame();
      chk("restart_addr0", {17'd0, rd_en, addr}, {17'd0, 1'b1, 14'd0});
      repeat (38399) @(posedge clk);
      #1;
      chk("before_done_busy", {30'd0, busy, frame_done}, 32'd2);
      start = 1'b1;
      @(posedge clk); #1;
      chk("frame_done_pulse", {30'd0, busy, frame_done}, 32'd1);
      chk("frame_all_pixels", 32'(exp_q.size()), 32'd0);
      chk("frame_pixel_count", 32'(hs_cnt), 32'(NPIX));

      // start still high one edge later: new frame from address 0.
      timing_on = 1'b0;
      for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_pix(i));
      rd_exp = 0;
      hs_cnt = 0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("frame_c_start", {15'd0, busy, frame_done, rd_en, addr}, {15'd0, 1'b1, 1'b0, 1'b1, 14'd0});
      chk("frame_done_count", 32'(fd_cnt), 32'd1);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      chk("final_reset_busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
